// File: rtl/dr_stream_sink_if.sv
// Data-ready stream sink bus: producer word/strobe in, valid/ready consumer side out.
interface dr_stream_sink_if #(
    parameter int unsigned DATA_W = 8
) ();
    logic [DATA_W-1:0] in_data;
    logic              in_dr;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;

    modport master (
        output in_data,
        output in_dr,
        output out_ready,
        input  out_data,
        input  out_valid
    );

    modport slave (
        input  in_data,
        input  in_dr,
        input  out_ready,
        output out_data,
        output out_valid
    );
endinterface

// File: rtl/dr_stream_sink.sv
// Captures dr-strobed words into a small FIFO, re-presents them on valid/ready,
// and checks that the strobed words count up by one, tallying errors and drops.
module dr_stream_sink #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned ADDR_W = 2,
    parameter int unsigned CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    dr_stream_sink_if.slave   bus,
    output logic [ADDR_W:0]   level,
    output logic              overflow,
    output logic [CNT_W-1:0]  drop_cnt,
    output logic [CNT_W-1:0]  seq_err_cnt
);

    localparam int unsigned      LVL_W    = ADDR_W + 1;
    localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    typedef enum logic {
        S_NOREF = 1'b0,
        S_TRACK = 1'b1
    } chk_state_e;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_wdata_d;
    logic              mem_we_d;

    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]  level_q, level_d;
    logic              overflow_q, overflow_d;
    logic [CNT_W-1:0]  drop_cnt_q, drop_cnt_d;
    logic [CNT_W-1:0]  seq_err_cnt_q, seq_err_cnt_d;
    chk_state_e        state_q, state_d;
    logic [DATA_W-1:0] ref_word_q, ref_word_d;

    logic valid_c;
    logic full_c;
    logic pop_c;
    logic push_c;
    logic drop_c;

    // Handshake decode; a full FIFO still accepts a word when the head leaves this cycle
    always_comb begin
        valid_c = (level_q != '0);
        full_c  = (level_q == FULL_LVL);
        pop_c   = valid_c && bus.out_ready;
        push_c  = bus.in_dr && (!full_c || pop_c);
        drop_c  = bus.in_dr && !push_c;
    end

    // FIFO pointers, level, overflow and drop accounting
    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        level_d     = level_q;
        overflow_d  = overflow_q;
        drop_cnt_d  = drop_cnt_q;
        mem_we_d    = push_c;
        mem_wdata_d = bus.in_data;

        if (push_c) begin
            wr_ptr_d = wr_ptr_q + ADDR_W'(1);
        end
        if (pop_c) begin
            rd_ptr_d = rd_ptr_q + ADDR_W'(1);
        end

        unique case ({push_c, pop_c})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase

        if (drop_c) begin
            overflow_d = 1'b1;
            if (drop_cnt_q != CNT_MAX) begin
                drop_cnt_d = drop_cnt_q + CNT_W'(1);
            end
        end
    end

    // Sequence checker: resynchronises on every received word, dropped or not
    always_comb begin
        state_d       = state_q;
        ref_word_d    = ref_word_q;
        seq_err_cnt_d = seq_err_cnt_q;

        if (bus.in_dr) begin
            unique case (state_q)
                S_NOREF: begin
                    ref_word_d = bus.in_data;
                    state_d    = S_TRACK;
                end
                S_TRACK: begin
                    if ((bus.in_data != (ref_word_q + DATA_W'(1))) &&
                        (seq_err_cnt_q != CNT_MAX)) begin
                        seq_err_cnt_d = seq_err_cnt_q + CNT_W'(1);
                    end
                    ref_word_d = bus.in_data;
                end
                default: begin
                    state_d = S_NOREF;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            level_q       <= '0;
            overflow_q    <= 1'b0;
            drop_cnt_q    <= '0;
            seq_err_cnt_q <= '0;
            state_q       <= S_NOREF;
            ref_word_q    <= '0;
        end else begin
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            level_q       <= level_d;
            overflow_q    <= overflow_d;
            drop_cnt_q    <= drop_cnt_d;
            seq_err_cnt_q <= seq_err_cnt_d;
            state_q       <= state_d;
            ref_word_q    <= ref_word_d;
        end
    end

    // Storage needs no reset: the head is masked to zero while empty
    always_ff @(posedge clk) begin
        if (mem_we_d) begin
            mem_q[wr_ptr_q] <= mem_wdata_d;
        end
    end

    assign bus.out_valid = valid_c;
    assign bus.out_data  = valid_c ? mem_q[rd_ptr_q] : '0;
    assign level         = level_q;
    assign overflow      = overflow_q;
    assign drop_cnt      = drop_cnt_q;
    assign seq_err_cnt   = seq_err_cnt_q;

endmodule

// File: tb/tb_dr_stream_sink.sv
// Directed self-checking bench for dr_stream_sink.
module tb_dr_stream_sink;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned DEPTH  = 4;
    localparam int unsigned ADDR_W = 2;
    localparam int unsigned CNT_W  = 8;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [ADDR_W:0]   level;
    logic              overflow;
    logic [CNT_W-1:0]  drop_cnt;
    logic [CNT_W-1:0]  seq_err_cnt;

    int total = 0;
    int bad   = 0;

    dr_stream_sink_if #(.DATA_W(DATA_W)) bus ();

    dr_stream_sink #(
        .DATA_W(DATA_W),
        .DEPTH (DEPTH),
        .ADDR_W(ADDR_W),
        .CNT_W (CNT_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus.slave),
        .level      (level),
        .overflow   (overflow),
        .drop_cnt   (drop_cnt),
        .seq_err_cnt(seq_err_cnt)
    );

    always #5 clk = ~clk;

    // Advance one clock and settle 1ns past the rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        bus.in_dr     = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        rst = 1'b0;
        step();
        step();
        step();
        rst = 1'b1;
        step();
    endtask

    task automatic test_reset();
        do_reset();
        for (int i = 0; i < 10; i++) step();
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%0h exp=0", bus.out_valid); end
        total++; if (level !== 3'd0) begin bad++; $display("FAIL reset_level got=%0d exp=0", level); end
        total++; if (bus.out_data !== 8'h00) begin bad++; $display("FAIL reset_data got=%0h exp=0", bus.out_data); end
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL reset_overflow got=%0h exp=0", overflow); end
        total++; if (drop_cnt !== 8'd0) begin bad++; $display("FAIL reset_drop got=%0d exp=0", drop_cnt); end
        total++; if (seq_err_cnt !== 8'd0) begin bad++; $display("FAIL reset_seq got=%0d exp=0", seq_err_cnt); end
    endtask

    task automatic test_single();
        do_reset();
        bus.in_data = 8'h2A;
        bus.in_dr   = 1'b1;
        step();
        bus.in_dr = 1'b0;
        total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL single_valid got=%0h exp=1", bus.out_valid); end
        total++; if (bus.out_data !== 8'h2A) begin bad++; $display("FAIL single_data got=%0h exp=2a", bus.out_data); end
        total++; if (level !== 3'd1) begin bad++; $display("FAIL single_level got=%0d exp=1", level); end
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL single_pop_valid got=%0h exp=0", bus.out_valid); end
        total++; if (level !== 3'd0) begin bad++; $display("FAIL single_pop_level got=%0d exp=0", level); end
        total++; if (bus.out_data !== 8'h00) begin bad++; $display("FAIL single_empty_data got=%0h exp=0", bus.out_data); end
    endtask

    task automatic test_overflow();
        logic [7:0] exp_w;
        do_reset();
        for (int i = 0; i < 6; i++) begin
            bus.in_data = 8'(i);
            bus.in_dr   = 1'b1;
            step();
        end
        bus.in_dr = 1'b0;
        total++; if (level !== 3'd4) begin bad++; $display("FAIL ovf_level got=%0d exp=4", level); end
        total++; if (bus.out_data !== 8'h00) begin bad++; $display("FAIL ovf_head got=%0h exp=0", bus.out_data); end
        total++; if (drop_cnt !== 8'd2) begin bad++; $display("FAIL ovf_drop got=%0d exp=2", drop_cnt); end
        total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_flag got=%0h exp=1", overflow); end
        total++; if (seq_err_cnt !== 8'd0) begin bad++; $display("FAIL ovf_seq got=%0d exp=0", seq_err_cnt); end
        bus.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            exp_w = 8'(i);
            total++; if (bus.out_valid !== 1'b1 || bus.out_data !== exp_w) begin bad++; $display("FAIL ovf_drain%0d got=%0h/%0h exp=1/%0h", i, bus.out_valid, bus.out_data, exp_w); end
            step();
        end
        bus.out_ready = 1'b0;
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL ovf_empty got=%0h exp=0", bus.out_valid); end
        total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_sticky got=%0h exp=1", overflow); end
    endtask

    task automatic test_full_push_pop();
        logic [7:0] exp_w;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            bus.in_data = 8'h10 + 8'(i);
            bus.in_dr   = 1'b1;
            step();
        end
        bus.in_data   = 8'h14;
        bus.out_ready = 1'b1;
        step();
        bus.in_dr     = 1'b0;
        bus.out_ready = 1'b0;
        total++; if (level !== 3'd4) begin bad++; $display("FAIL fpp_level got=%0d exp=4", level); end
        total++; if (drop_cnt !== 8'd0) begin bad++; $display("FAIL fpp_drop got=%0d exp=0", drop_cnt); end
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL fpp_overflow got=%0h exp=0", overflow); end
        bus.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            exp_w = 8'h11 + 8'(i);
            total++; if (bus.out_valid !== 1'b1 || bus.out_data !== exp_w) begin bad++; $display("FAIL fpp_drain%0d got=%0h/%0h exp=1/%0h", i, bus.out_valid, bus.out_data, exp_w); end
            step();
        end
        bus.out_ready = 1'b0;
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL fpp_empty got=%0h exp=0", bus.out_valid); end
    endtask

    task automatic test_seq_wrap();
        logic [7:0] words [6];
        words = '{8'hFE, 8'hFF, 8'h00, 8'h01, 8'h07, 8'h08};
        do_reset();
        bus.out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            bus.in_data = words[i];
            bus.in_dr   = 1'b1;
            step();
            // a gap between words must not matter
            if (i == 2) begin
                bus.in_dr = 1'b0;
                step();
                step();
            end
        end
        bus.in_dr = 1'b0;
        total++; if (seq_err_cnt !== 8'd1) begin bad++; $display("FAIL seq_errs got=%0d exp=1", seq_err_cnt); end
        bus.in_data = 8'h09;
        bus.in_dr   = 1'b1;
        step();
        bus.in_dr     = 1'b0;
        bus.out_ready = 1'b0;
        total++; if (seq_err_cnt !== 8'd1) begin bad++; $display("FAIL seq_resync got=%0d exp=1", seq_err_cnt); end
        total++; if (drop_cnt !== 8'd0) begin bad++; $display("FAIL seq_drop got=%0d exp=0", drop_cnt); end
    endtask

    task automatic test_async_reset();
        do_reset();
        // third word jumps, so the error counter is non-zero before the reset
        bus.in_dr = 1'b1;
        bus.in_data = 8'h30; step();
        bus.in_data = 8'h31; step();
        bus.in_data = 8'h33; step();
        bus.in_dr = 1'b0;
        total++; if (level !== 3'd3) begin bad++; $display("FAIL ar_pre_level got=%0d exp=3", level); end
        total++; if (seq_err_cnt !== 8'd1) begin bad++; $display("FAIL ar_pre_seq got=%0d exp=1", seq_err_cnt); end
        #2;
        rst = 1'b0;
        #1;
        total++; if (level !== 3'd0) begin bad++; $display("FAIL ar_level got=%0d exp=0", level); end
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL ar_valid got=%0h exp=0", bus.out_valid); end
        total++; if (seq_err_cnt !== 8'd0) begin bad++; $display("FAIL ar_seq got=%0d exp=0", seq_err_cnt); end
        total++; if (bus.out_data !== 8'h00) begin bad++; $display("FAIL ar_data got=%0h exp=0", bus.out_data); end
        step();
        rst = 1'b1;
        step();
        bus.in_dr = 1'b1;
        bus.in_data = 8'h50; step();
        bus.in_data = 8'h51; step();
        bus.in_dr = 1'b0;
        total++; if (seq_err_cnt !== 8'd0) begin bad++; $display("FAIL ar_post_seq got=%0d exp=0", seq_err_cnt); end
        total++; if (bus.out_data !== 8'h50) begin bad++; $display("FAIL ar_post_head got=%0h exp=50", bus.out_data); end
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        total++; if (bus.out_data !== 8'h51) begin bad++; $display("FAIL ar_post_next got=%0h exp=51", bus.out_data); end
        total++; if (level !== 3'd1) begin bad++; $display("FAIL ar_post_level got=%0d exp=1", level); end
    endtask

    initial begin
        bus.in_dr     = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        test_reset();
        test_single();
        test_overflow();
        test_full_push_pop();
        test_seq_wrap();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dr_stream_sink.md
Name: dr_stream_sink

Overview:
Receiving end of the data-ready stream (data bus plus dr strobe) produced by the counter/data top.
- Captures every word strobed by dr into a small FIFO.
- Re-presents the words to a downstream consumer on a valid/ready handshake.
- Checks that successive strobed words increment by one (mod 2^DATA_W), counts sequence errors and words dropped on overflow.

Parameters:
DATA_W, 8, width of data words
DEPTH, 4, FIFO depth in words; power of two, >= 2
ADDR_W, 2, log2(DEPTH)
CNT_W, 8, width of the saturating error/drop counters

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  asynchronous, active-low reset (0 = reset asserted)
in_data  in  DATA_W  stream word from the producer
in_dr  in  1  data ready; each clk cycle with in_dr=1 presents one word
out_data  out  DATA_W  FIFO head word
out_valid  out  1  FIFO non-empty
out_ready  in  1  consumer accepts the head word when out_valid && out_ready
level  out  ADDR_W+1  words currently stored, 0..DEPTH
overflow  out  1  sticky; set on first dropped word
drop_cnt  out  CNT_W  words dropped because FIFO full, saturating
seq_err_cnt  out  CNT_W  sequence mismatches, saturating

Behaviour:
- Reset (rst=0, asynchronous):
  - Clears pointers, level, overflow, drop_cnt, seq_err_cnt.
  - Checker returns to state NOREF.
  - Outputs read out_valid=0, level=0, out_data=0. Memory contents are don't-care but out_data must read 0 while empty.
- Push: in_dr=1 and (level<DEPTH or pop in same cycle).
  - Write in_data at wr_ptr; wr_ptr increments and wraps mod DEPTH.
- Pop: out_valid && out_ready; rd_ptr increments and wraps mod DEPTH.
- Level update: push only +1; pop only -1; push and pop together leaves level unchanged, including at level=DEPTH.
- Latency:
  - A word pushed into an empty FIFO appears on out_data with out_valid=1 the next cycle.
  - No same-cycle bypass, so an empty FIFO never pops.
- Full: in_dr=1, level=DEPTH and no pop.
  - Word is discarded and FIFO contents are unchanged.
  - drop_cnt increments, holding at 2^CNT_W-1.
  - overflow is set and stays set until reset.
- out_data: combinational read of mem[rd_ptr] when out_valid=1; 0 when empty.
- Sequence checker FSM (evaluated on every in_dr=1 cycle, including dropped words):
  - NOREF: load ref <= in_data, go to TRACK, no error.
  - TRACK: if in_data != ref+1 (mod 2^DATA_W), increment seq_err_cnt (saturating). Then ref <= in_data.
  - Resynchronises on the received value, so one glitch costs one error; a jump back to the expected sequence costs one more.
  - Wrap 0xFF->0x00 is legal, not an error.
- in_dr=0 cycles: no effect on FIFO or checker. Gaps of any length are legal.
- Reset asserted mid-stream: all in-flight words are lost and the checker re-acquires on the first word after reset release. No error is counted for the discontinuity.
- All outputs are registered except out_data and out_valid, which are derived from registered pointers/memory.

Test Plan:
1. Reset then idle: rst=0 for 3 cycles, release, in_dr=0 for 10 cycles -> out_valid=0, level=0, out_data=0, overflow=0, both counters 0.
2. Single word: in_dr=1 with in_data=0x2A for 1 cycle, out_ready=0 -> next cycle out_valid=1, out_data=0x2A, level=1. Then out_ready=1 for 1 cycle -> out_valid=0, level=0.
3. Overflow: out_ready=0, push 0x00..0x05 on 6 consecutive cycles -> level=4, head 0x00, drop_cnt=2, overflow=1, seq_err_cnt=0. Drain with out_ready=1 -> 0x00,0x01,0x02,0x03 in order, then out_valid=0. overflow remains 1.
4. Full with simultaneous push/pop: fill to 4 (0x10..0x13), then one cycle with in_dr=1 (0x14) and out_ready=1 -> level stays 4, drop_cnt=0, drained order 0x11,0x12,0x13,0x14.
5. Sequence errors and wrap: stream 0xFE,0xFF,0x00,0x01,0x07,0x08 -> seq_err_cnt=1 (at 0x07 only). Continue with 0x09 -> still 1.
6. Async reset mid-stream: apply rst=0 between clock edges while level=3 -> level, out_valid, counters clear immediately without a clock edge. After release, stream 0x50,0x51 -> seq_err_cnt=0, outputs 0x50,0x51.
